// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and shamt width.
// Rotate support is selected by the SHIFTER_ROTATE_EN macro in the stage logic.
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  // Number of shift-amount bits, which is also the number of pipeline stages.
  function automatic int shamt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of pipe_shifter: conditional shift by 2^STAGE plus its register slice.
// With SHIFTER_ROTATE_EN defined op 11 rotates right; otherwise it behaves as SRL.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STAGE = 0,
  parameter int TAG_W = 4,
  localparam int SW = shamt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic [SW-1:0]    up_shamt,
  input  shift_op_e        up_op,
  input  logic [TAG_W-1:0] up_tag,
  input  logic             up_sign,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data,
  output logic [SW-1:0]    dn_shamt,
  output shift_op_e        dn_op,
  output logic [TAG_W-1:0] dn_tag,
  output logic             dn_sign
);

  localparam int AMT = 1 << STAGE;

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = up_data;
    if (up_shamt[STAGE]) begin
      case (up_op)
        OP_SLL:  shifted = up_data << AMT;
        // Fill with the sign captured at acceptance, not the current MSB.
        OP_SRA:  shifted = {{AMT{up_sign}}, up_data[WIDTH-1:AMT]};
`ifdef SHIFTER_ROTATE_EN
        OP_ROR:  shifted = {up_data[AMT-1:0], up_data[WIDTH-1:AMT]};
`endif
        default: shifted = up_data >> AMT;
      endcase
    end
  end

  // Handshake: a transfer happens on an edge where valid && ready are both high.
  // This slice can take a new op when it is empty or its content leaves this edge.
  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
      dn_shamt <= '0;
      dn_op    <= OP_SLL;
      dn_tag   <= '0;
      dn_sign  <= 1'b0;
    end else if (flush) begin
      dn_valid <= 1'b0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_data  <= shifted;
        dn_shamt <= up_shamt;
        dn_op    <= up_op;
        dn_tag   <= up_tag;
        dn_sign  <= up_sign;
      end
    end
  end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: one shift_stage per shamt bit, valid/ready on both ends.
// Define SHIFTER_ROTATE_EN to make op 11 a rotate-right instead of SRL.
module pipe_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int S = shamt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [S-1:0]     in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  // Index 0 is the input port; index k+1 is the output of stage k.
  logic             valid_c [0:S];
  logic             ready_c [0:S];
  logic [WIDTH-1:0] data_c  [0:S];
  logic [S-1:0]     shamt_c [0:S];
  shift_op_e        op_c    [0:S];
  logic [TAG_W-1:0] tag_c   [0:S];
  logic             sign_c  [0:S];

  assign valid_c[0] = in_valid;
  assign data_c[0]  = in_data;
  assign shamt_c[0] = in_shamt;
  assign op_c[0]    = shift_op_e'(in_op);
  assign tag_c[0]   = in_tag;
  assign sign_c[0]  = in_data[WIDTH-1];
  assign ready_c[S] = out_ready;
  assign in_ready   = ready_c[0];

  for (genvar k = 0; k < S; k++) begin : g_stage
    shift_stage #(
      .WIDTH(WIDTH),
      .STAGE(k),
      .TAG_W(TAG_W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (valid_c[k]),
      .up_ready (ready_c[k]),
      .up_data  (data_c[k]),
      .up_shamt (shamt_c[k]),
      .up_op    (op_c[k]),
      .up_tag   (tag_c[k]),
      .up_sign  (sign_c[k]),
      .dn_valid (valid_c[k+1]),
      .dn_ready (ready_c[k+1]),
      .dn_data  (data_c[k+1]),
      .dn_shamt (shamt_c[k+1]),
      .dn_op    (op_c[k+1]),
      .dn_tag   (tag_c[k+1]),
      .dn_sign  (sign_c[k+1])
    );
  end

  assign out_valid = valid_c[S];
  assign out_data  = data_c[S];
  assign out_tag   = tag_c[S];

  // Control sideband is no longer needed once the last stage has shifted.
  logic unused_tail;
  assign unused_tail = ^{shamt_c[S], op_c[S], sign_c[S]};

endmodule

// File: tb/tb_pipe_shifter.sv
// Bench for pipe_shifter: a 32-bit instance checked against a reference model and
// an 8-bit instance checked with literal vectors; honours SHIFTER_ROTATE_EN.
module tb_pipe_shifter;

  localparam int S32 = 5;
  localparam int S8  = 3;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;

  logic        b_valid;
  logic        b_ready;
  logic [7:0]  b_data;
  logic [2:0]  b_shamt;
  logic [1:0]  b_op;
  logic [3:0]  b_tag;
  logic        b_out_valid;
  logic [7:0]  b_out_data;
  logic [3:0]  b_out_tag;
  logic        b_flush;
  logic        b_out_ready;

  int vectors;
  int miscompares;

  logic [35:0] exp_q[$];

  pipe_shifter #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  pipe_shifter #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .in_shamt(b_shamt), .in_op(b_op), .in_tag(b_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_tag(b_out_tag)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                        input logic [1:0] op);
    logic [31:0] r;
    case (op)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = 32'($signed(d) >>> s);
`ifdef SHIFTER_ROTATE_EN
      default: r = (d >> s) | (d << (6'd32 - {1'b0, s}));
`else
      default: r = d >> s;
`endif
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", {28'd0, out_tag, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("sb_data", 64'(out_data), 64'(e[31:0]));
            check("sb_tag", 64'(out_tag), 64'(e[35:32]));
          end
        end
        if (flush) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back({in_tag, model(in_data, in_shamt, in_op)});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step(input logic v, input logic [31:0] d, input logic [4:0] s,
                      input logic [1:0] op, input logic [3:0] tg, output logic acc);
    in_valid = v; in_data = d; in_shamt = s; in_op = op; in_tag = tg;
    #1;
    acc = v && in_ready && !flush;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic single(input string name, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] op, input logic [3:0] tg, input logic [31:0] exp_d);
    logic acc;
    int n;
    step(1'b1, d, s, op, tg, acc);
    check({name, "_acc"}, 64'(acc), 64'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_lat"}, 64'(n), 64'(S32 - 1));
    check({name, "_data"}, 64'(out_data), 64'(exp_d));
    check({name, "_tag"}, 64'(out_tag), 64'(tg));
    @(posedge clk); #1;
  endtask

  task automatic single8(input string name, input logic [7:0] d, input logic [2:0] s,
                         input logic [1:0] op, input logic [3:0] tg, input logic [7:0] exp_d);
    int n;
    b_valid = 1'b1; b_data = d; b_shamt = s; b_op = op; b_tag = tg;
    #1;
    check({name, "_ready"}, 64'(b_ready), 64'd1);
    @(posedge clk); #1;
    b_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_lat"}, 64'(n), 64'(S8 - 1));
    check({name, "_data"}, 64'(b_out_data), 64'(exp_d));
    check({name, "_tag"}, 64'(b_out_tag), 64'(tg));
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic acc;
    int run, maxrun, acc_cnt, seen, j;
    logic [31:0] d;
    vectors = 0; miscompares = 0;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
    b_valid = 1'b0; b_data = '0; b_shamt = '0; b_op = '0; b_tag = '0;
    b_flush = 1'b0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // 8-bit literal vectors
    single8("w8_sll", 8'h96, 3'd3, 2'b00, 4'h1, 8'hB0);
    single8("w8_srl", 8'h96, 3'd3, 2'b01, 4'h2, 8'h12);
    single8("w8_sra", 8'h96, 3'd3, 2'b10, 4'h3, 8'hF2);
`ifdef SHIFTER_ROTATE_EN
    single8("w8_ror", 8'h96, 3'd3, 2'b11, 4'h4, 8'hD2);
`else
    single8("w8_op3", 8'h96, 3'd3, 2'b11, 4'h4, 8'h12);
`endif

    // 32-bit edge cases with literal expectations
    single("sra31", 32'h8000_0000, 5'd31, 2'b10, 4'h3, 32'hFFFF_FFFF);
    single("sll31", 32'h0000_0001, 5'd31, 2'b00, 4'h5, 32'h8000_0000);
    single("srl4", 32'h1234_5678, 5'd4, 2'b01, 4'h6, 32'h0123_4567);
    single("sra4_pos", 32'h7000_0000, 5'd4, 2'b10, 4'h7, 32'h0700_0000);
    for (int i = 0; i < 4; i++)
      single("shamt0", 32'hDEAD_BEEF, 5'd0, 2'(i), 4'(8 + i), 32'hDEAD_BEEF);
`ifdef SHIFTER_ROTATE_EN
    single("ror8", 32'h1234_5678, 5'd8, 2'b11, 4'hC, 32'h7812_3456);
`else
    single("op3_8", 32'h1234_5678, 5'd8, 2'b11, 4'hC, 32'h0012_3456);
`endif

    // back-to-back stream of 20 ops
    run = 0; maxrun = 0;
    for (int i = 0; i < 20 + S32 + 2; i++) begin
      d = 32'hA5C3_0F17 ^ (32'(i) * 32'h0101_0111);
      if (i < 20) begin
        step(1'b1, d, 5'((i * 7) % 32), 2'(i % 4), 4'(i), acc);
        check("stream_in_ready", 64'(acc), 64'd1);
      end else begin
        step(1'b0, d, 5'd0, 2'b00, 4'h0, acc);
      end
      run = out_valid ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    check("stream_run", 64'(maxrun), 64'd20);

    // stall with continuous offers
    out_ready = 1'b0;
    acc_cnt = 0; j = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'hF000_0001 + 32'(j) * 32'h1111, 5'(j + 1), 2'(j % 3), 4'(j), acc);
      if (acc) begin acc_cnt++; j++; end
    end
    check("stall_accepted", 64'(acc_cnt), 64'(S32));
    check("stall_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    repeat (S32 + 3) @(posedge clk);
    #1;
    check("stall_drained", 64'(exp_q.size()), 64'd0);

    // flush with three ops in flight plus one offered
    for (int i = 0; i < 3; i++) step(1'b1, 32'h0F0F_0F0F, 5'(i + 1), 2'b00, 4'(i), acc);
    flush = 1'b1;
    step(1'b1, 32'h5555_AAAA, 5'd2, 2'b01, 4'hF, acc);
    flush = 1'b0;
    seen = 0;
    repeat (S32 + 3) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_no_out", 64'(seen), 64'd0);
    single("post_flush", 32'h0000_00F0, 5'd4, 2'b01, 4'h9, 32'h0000_000F);

    // reset mid-stream
    for (int i = 0; i < 2; i++) step(1'b1, 32'h1357_9BDF, 5'd1, 2'b00, 4'hA, acc);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    check("midrst_out_tag", 64'(out_tag), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    seen = 0;
    repeat (S32 + 2) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_out", 64'(seen), 64'd0);
    single("post_rst", 32'hC000_0000, 5'd30, 2'b10, 4'h2, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
